// File: rtl/mips_pkg.sv
// Shared widths, fetch FSM encoding and reset PC for the MIPS fetch slice.
package mips_pkg;

   localparam int OP_W  = 6;
   localparam int REG_W = 5;
   localparam int IMM_W = 16;
   localparam int TGT_W = 26;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

   // Branch offsets count words, so the sign-extended immediate is scaled by 4.
   function automatic logic [31:0] branch_offset(input logic [IMM_W-1:0] imm);
      return {{14{imm[IMM_W-1]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/mips_instr_fields.sv
// Splits a 32-bit MIPS instruction word into its R/I/J-format fields.
module mips_instr_fields
   import mips_pkg::*;
(
   input  logic [31:0]      instr,
   output logic [OP_W-1:0]  opcode,
   output logic [REG_W-1:0] rs,
   output logic [REG_W-1:0] rt,
   output logic [REG_W-1:0] rd,
   output logic [REG_W-1:0] shamt,
   output logic [OP_W-1:0]  funct,
   output logic [IMM_W-1:0] imm,
   output logic [TGT_W-1:0] target
);

   assign opcode = instr[31:26];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];
   assign shamt  = instr[10:6];
   assign funct  = instr[5:0];
   assign imm    = instr[15:0];
   assign target = instr[25:0];

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction fetch stage: owns the PC, reads imem over req/ack, holds the word
// until decode consumes it, then applies the selected redirect.
module mips_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [15:0]      branch_imm,
   input  logic             jump,
   input  logic [25:0]      jump_target,
   input  logic             jump_reg,
   input  logic [31:0]      jr_addr,
   output logic [31:0]      pc_out,
   output logic [31:0]      pc_plus4,
   output logic [31:0]      instr,
   output logic             instr_valid,
   output logic [OP_W-1:0]  opcode,
   output logic [REG_W-1:0] rs,
   output logic [REG_W-1:0] rt,
   output logic [REG_W-1:0] rd,
   output logic [REG_W-1:0] shamt,
   output logic [OP_W-1:0]  funct,
   output logic [IMM_W-1:0] imm,
   output logic [TGT_W-1:0] target,
   output logic [1:0]       state_dbg
);

   // Handshakes: imem_req stays high in FETCH until a cycle with imem_ack
   // (same-cycle ack allowed); the held instruction is consumed on any HOLD
   // cycle with stall low, which is also the only cycle redirects are sampled.

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic         valid_q, valid_d;
   logic [31:0]  next_pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = FETCH;
         FETCH:   if (imem_ack) state_d = HOLD;
         HOLD:    if (!stall)   state_d = FETCH;
         default: state_d = IDLE;
      endcase
   end

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      next_pc = pc_plus4;
      if (jump_reg)          next_pc = jr_addr & 32'hFFFF_FFFC;
      else if (jump)         next_pc = {pc_plus4[31:28], jump_target, 2'b00};
      else if (branch_taken) next_pc = pc_plus4 + branch_offset(branch_imm);
   end

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      if (state_q == FETCH && imem_ack) begin
         instr_d = imem_rdata;
         valid_d = 1'b1;
      end else if (state_q == HOLD && !stall) begin
         pc_d    = next_pc;
         valid_d = 1'b0;
      end
   end

   always_comb begin
      imem_req    = (state_q == FETCH);
      imem_addr   = pc_q;
      pc_out      = pc_q;
      instr       = instr_q;
      instr_valid = valid_q;
      state_dbg   = state_q;
   end

   mips_instr_fields u_fields (
      .instr  (instr_q),
      .opcode (opcode),
      .rs     (rs),
      .rt     (rt),
      .rd     (rd),
      .shamt  (shamt),
      .funct  (funct),
      .imm    (imm),
      .target (target)
   );

endmodule
